// File: rtl/gf_mul_sched.sv
// gf_mul_sched: schedules GF(2^W) multiply operations from two requesters
// onto an external fixed-latency multiplier array and buffers the products
// in a small result FIFO. Issue is credit-limited, so the FIFO can never
// overflow, and the two requesters are served round-robin.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. Requesters hold valid and their operands stable
// until ready is seen, and valid never depends on ready. rN_ready is
// combinational and is high only in the cycle requester N is granted.
// On the result side, res_valid means the FIFO head is presented on
// res_data/res_id, and res_valid & res_ready pops that entry.
module gf_mul_sched #(
    parameter int           W        = 16,
    parameter int           LAT      = 12,
    parameter int           OFD      = 4,
    parameter logic [W-1:0] POLY_RST = 16'h100B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_poly,
    output logic         busy,
    output logic         ctr,
    output logic [W-1:0] ai,
    output logic [W-1:0] bi,
    output logic [W-1:0] gi,
    input  logic [W-1:0] po,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_id
);

    // Counters must hold up to LAT + OFD without wrapping.
    localparam int CW = $clog2(LAT + OFD + 1);
    localparam int PW = (OFD > 1) ? $clog2(OFD) : 1;

    logic          rr_prio;     // requester that wins the next conflict
    logic          iss_id;      // id of the operation currently on ai/bi
    logic [CW-1:0] inflight;    // issued, not yet written into the FIFO
    logic [CW-1:0] occ;         // FIFO occupancy
    logic [CW:0]   total;
    logic          credit_ok;
    logic          cfg_accept;
    logic          gnt_any;
    logic          gnt_id;
    logic          issue;

    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic           wr_en;
    logic           pop;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  fifo_data [OFD];
    logic          fifo_id   [OFD];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OFD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit, busy and configuration acceptance.
    assign total      = {1'b0, inflight} + {1'b0, occ};
    assign credit_ok  = total < (CW + 1)'(OFD);
    assign busy       = (total != '0);
    assign cfg_accept = cfg_we & ~busy;

    // Round-robin grant; a configuration write takes the cycle, and
    // nothing is granted while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (r0_valid && r1_valid) begin
            gnt_any = 1'b1;
            gnt_id  = rr_prio;
        end else if (r0_valid) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
        end else if (r1_valid) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
        end
        issue    = gnt_any & credit_ok & ~cfg_accept & rst;
        r0_ready = issue & ~gnt_id;
        r1_ready = issue & gnt_id;
    end

    // Array operand registers, start pulse and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr     <= 1'b0;
            ai      <= '0;
            bi      <= '0;
            iss_id  <= 1'b0;
            rr_prio <= 1'b0;
        end else begin
            ctr <= issue;
            if (issue) begin
                ai      <= gnt_id ? r1_a : r0_a;
                bi      <= gnt_id ? r1_b : r0_b;
                iss_id  <= gnt_id;
                rr_prio <= ~gnt_id;
            end
        end
    end

    // Field polynomial register, writable only while nothing is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gi <= POLY_RST;
        end else if (cfg_accept) begin
            gi <= cfg_poly;
        end
    end

    // Tag pipeline: stage 0 loads on the edge the array samples ctr, so the
    // last stage lines up with the edge po carries that product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= ctr;
            tag_id[0] <= iss_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign wr_en     = tag_v[LAT-1];
    assign res_valid = (occ != '0);
    assign pop       = res_valid & res_ready;
    assign res_data  = fifo_data[rd_ptr];
    assign res_id    = fifo_id[rd_ptr];

    // In-flight counter: up on issue, down when the product lands in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({issue, wr_en})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Result FIFO storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < OFD; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= 1'b0;
            end
        end else begin
            if (wr_en) begin
                fifo_data[wr_ptr] <= po;
                fifo_id[wr_ptr]   <= tag_id[LAT-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mul_sched.sv
// Bench for gf_mul_sched: a behavioural multiplier array with LAT cycles of
// latency feeds po; directed scenarios check arbitration, credits, config
// and reset behaviour against hand-computed products.
module tb_gf_mul_sched;

    localparam int W   = 16;
    localparam int LAT = 12;
    localparam int OFD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_valid, r1_valid;
    logic         r0_ready, r1_ready;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic         cfg_we;
    logic [W-1:0] cfg_poly;
    logic         busy, ctr;
    logic [W-1:0] ai, bi, gi, po;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_id;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    gf_mul_sched #(.W(W), .LAT(LAT), .OFD(OFD), .POLY_RST(16'h100B)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .cfg_we(cfg_we), .cfg_poly(cfg_poly), .busy(busy), .ctr(ctr),
        .ai(ai), .bi(bi), .gi(gi), .po(po),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    // Clock.
    always #5 clk = ~clk;

    // Behavioural array: product of ai*bi mod gi, visible LAT edges after
    // the edge that samples ctr high; zero when no operation was started.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] g);
        logic [W-1:0] p;
        p = '0;
        for (int i = W - 1; i >= 0; i--) begin
            p = {p[W-2:0], 1'b0} ^ (p[W-1] ? g : '0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= ctr ? gf_mul(ai, bi, gi) : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign po = pipe[LAT-1];

    // Driver: present one op and hold it until granted (bounded).
    task automatic issue_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit ok);
        ok = 0;
        @(negedge clk);
        if (id) begin r1_valid = 1; r1_a = a; r1_b = b; end
        else    begin r0_valid = 1; r0_a = a; r0_b = b; end
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if ((id ? r1_ready : r0_ready) === 1'b1) ok = 1;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        #1;
        r0_valid = 0;
        r1_valid = 0;
    endtask

    // Driver: wait (bounded) for one result and pop it.
    task automatic wait_result(input int budget, output logic [W-1:0] d, output logic id,
                               output bit got);
        got = 0; d = '0; id = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                d = res_data; id = res_id; got = 1;
                res_ready = 1;
                @(posedge clk);
                #1;
                res_ready = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; r0_valid = 0; r1_valid = 0; cfg_we = 0; res_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        logic [W-1:0] d; logic id; bit got;
        rst = 0; r0_valid = 1; r1_valid = 0; r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        cfg_we = 0; cfg_poly = '0; res_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ctr !== 1'b0) begin errors++; $display("FAIL reset_ctr got %b want 0", ctr); end
        checks++; if ({ai, bi} !== 32'h0) begin errors++; $display("FAIL reset_ai_bi got %h %h want 0 0", ai, bi); end
        checks++; if (gi !== 16'h100B) begin errors++; $display("FAIL reset_gi got %h want 100b", gi); end
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {r0_ready, r1_ready}); end
        checks++; if ({res_valid, res_id, busy} !== 3'b000) begin errors++; $display("FAIL reset_res_busy got %b want 000", {res_valid, res_id, busy}); end
        checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
        // First issue on the very first edge after release.
        @(negedge clk);
        rst = 1; r0_a = 16'h0003; r0_b = 16'h0003;
        #1;
        checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL first_edge_ready got %b want 1", r0_ready); end
        @(posedge clk); #1;
        r0_valid = 0;
        checks++; if (ctr !== 1'b1) begin errors++; $display("FAIL first_edge_ctr got %b want 1", ctr); end
        wait_result(LAT + 10, d, id, got);
        checks++; if (!got || d !== 16'h0005) begin errors++; $display("FAIL first_edge_result got %h (seen %0d) want 0005", d, got); end
    endtask

    task automatic test_single_op();
        logic [W-1:0] d; logic id; bit got;
        @(negedge clk);
        r0_valid = 1; r0_a = 16'h0003; r0_b = 16'h0003;
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {r0_ready, r1_ready}); end
        @(posedge clk); #1;
        r0_valid = 0;
        checks++; if ({ctr, ai, bi, busy} !== {1'b1, 16'h0003, 16'h0003, 1'b1}) begin
            errors++; $display("FAIL single_issue got ctr=%b ai=%h bi=%h busy=%b want 1 0003 0003 1", ctr, ai, bi, busy); end
        @(posedge clk); #1;
        checks++; if ({ctr, ai} !== {1'b0, 16'h0003}) begin errors++; $display("FAIL single_ctr_pulse got ctr=%b ai=%h want 0 0003", ctr, ai); end
        wait_result(LAT + 10, d, id, got);
        checks++; if (!got || d !== 16'h0005 || id !== 1'b0) begin
            errors++; $display("FAIL single_result got %h id %b (seen %0d) want 0005 id 0", d, id, got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reduction();
        logic [W-1:0] d; logic id; bit got; bit ok;
        issue_op(1'b0, 16'h0002, 16'h8000, ok);
        wait_result(LAT + 10, d, id, got);
        checks++; if (!ok || !got || d !== 16'h100B) begin errors++; $display("FAIL reduce_default got %h (seen %0d) want 100b", d, got); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reduce_busy got %b want 0", busy); end
        cfg_we = 1; cfg_poly = 16'h002D;
        @(posedge clk); #1;
        cfg_we = 0;
        checks++; if (gi !== 16'h002D) begin errors++; $display("FAIL reduce_cfg got gi=%h want 002d", gi); end
        issue_op(1'b0, 16'h0002, 16'h8000, ok);
        wait_result(LAT + 10, d, id, got);
        checks++; if (!ok || !got || d !== 16'h002D) begin errors++; $display("FAIL reduce_newpoly got %h (seen %0d) want 002d", d, got); end
    endtask

    task automatic test_contention();
        logic [W-1:0] a0 [4]; logic [W-1:0] b0 [4];
        logic [W-1:0] a1 [4]; logic [W-1:0] b1 [4];
        logic [W-1:0] d; logic id; bit got; int k0; int k1; logic [W:0] e;
        a0[0] = 16'h0003; b0[0] = 16'h0003; a0[1] = 16'h0005; b0[1] = 16'h0007;
        a1[0] = 16'h0002; b1[0] = 16'h8000; a1[1] = 16'h1234; b1[1] = 16'h0010;
        for (int i = 2; i < 4; i++) begin a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0; end
        exp_q = {};
        exp_q.push_back({1'b0, 16'h0005}); exp_q.push_back({1'b1, 16'h100B});
        exp_q.push_back({1'b0, 16'h001B}); exp_q.push_back({1'b1, 16'h334B});
        do_reset();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            r0_valid = 1; r0_a = a0[k0 % 4]; r0_b = b0[k0 % 4];
            r1_valid = 1; r1_a = a1[k1 % 4]; r1_b = b1[k1 % 4];
            #1;
            checks++; if ({r0_ready, r1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_grant%0d got %b want %b", c, {r0_ready, r1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01); end
            if (r0_ready) k0++;
            if (r1_ready) k1++;
            @(posedge clk);
        end
        @(negedge clk);
        r0_valid = 0; r1_valid = 0;
        for (int n = 0; n < 4; n++) begin
            wait_result(LAT + 10, d, id, got);
            e = exp_q.pop_front();
            checks++; if (!got || {id, d} !== e) begin
                errors++; $display("FAIL contention_result%0d got id %b data %h (seen %0d) want id %b data %h", n, id, d, got, e[W], e[W-1:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d; logic id; bit got; int grants; logic [W:0] e;
        exp_q = {};
        res_ready = 0;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0_valid = 1; r0_a = 16'h0003; r0_b = 16'h0003;
            r1_valid = 1; r1_a = 16'h0003; r1_b = 16'h0003;
            #1;
            if (r0_ready | r1_ready) begin grants++; exp_q.push_back({r1_ready, 16'h0005}); end
        end
        checks++; if (grants != OFD) begin errors++; $display("FAIL bp_issue_count got %0d want %0d", grants, OFD); end
        checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL bp_stalled got %b want 00", {r0_ready, r1_ready}); end
        wait_result(LAT + 10, d, id, got);
        e = exp_q.pop_front();
        checks++; if (!got || {id, d} !== {1'b0, 16'h0005} || e[W] !== 1'b0) begin
            errors++; $display("FAIL bp_first_pop got id %b data %h (seen %0d) want id 0 data 0005", id, d, got); end
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (r0_ready | r1_ready) begin grants++; exp_q.push_back({r1_ready, 16'h0005}); end
        end
        checks++; if (grants != 1) begin errors++; $display("FAIL bp_refill got %0d issues want 1", grants); end
        r0_valid = 0; r1_valid = 0;
        for (int n = 0; n < 4; n++) begin
            wait_result(LAT + 10, d, id, got);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++; if (!got || d !== 16'h0005 || id !== ((n % 2 == 0) ? 1'b1 : 1'b0) || id !== e[W]) begin
                errors++; $display("FAIL bp_drain%0d got id %b data %h (seen %0d) want id %b data 0005", n, id, d, got, (n % 2 == 0) ? 1'b1 : 1'b0); end
        end
    endtask

    task automatic test_cfg();
        logic [W-1:0] d; logic id; bit got; bit ok;
        issue_op(1'b0, 16'h0003, 16'h0003, ok);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_busy got %b want 1", busy); end
        cfg_we = 1; cfg_poly = 16'h0077;
        @(posedge clk); #1;
        cfg_we = 0;
        checks++; if (gi !== 16'h100B) begin errors++; $display("FAIL cfg_ignored got gi=%h want 100b", gi); end
        wait_result(LAT + 10, d, id, got);
        checks++; if (!ok || !got || d !== 16'h0005) begin errors++; $display("FAIL cfg_busy_result got %h (seen %0d) want 0005", d, got); end
        @(negedge clk);
        cfg_we = 1; cfg_poly = 16'h002D;
        r1_valid = 1; r1_a = 16'h0002; r1_b = 16'h8000;
        #1;
        checks++; if ({busy, r1_ready} !== 2'b00) begin errors++; $display("FAIL cfg_wins got busy,r1_ready=%b want 00", {busy, r1_ready}); end
        @(posedge clk); #1;
        cfg_we = 0;
        checks++; if (gi !== 16'h002D) begin errors++; $display("FAIL cfg_update got gi=%h want 002d", gi); end
        @(negedge clk); #1;
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL cfg_late_grant got %b want 1", r1_ready); end
        @(posedge clk); #1;
        r1_valid = 0;
        wait_result(LAT + 10, d, id, got);
        checks++; if (!got || {id, d} !== {1'b1, 16'h002D}) begin
            errors++; $display("FAIL cfg_result got id %b data %h (seen %0d) want id 1 data 002d", id, d, got); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d; logic id; bit got; bit ok; int seen; int grants;
        grants = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            r0_valid = 1; r0_a = 16'h0003; r0_b = 16'h0003;
            #1;
            if (r0_ready) grants++;
        end
        checks++; if (grants != 3) begin errors++; $display("FAIL rstmid_issue got %0d want 3", grants); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if ({ctr, r0_ready, r1_ready, res_valid, res_id, busy} !== 6'b0) begin
            errors++; $display("FAIL rstmid_ctrl got %b want 000000", {ctr, r0_ready, r1_ready, res_valid, res_id, busy}); end
        checks++; if ({ai, bi, res_data, gi} !== {16'h0, 16'h0, 16'h0, 16'h100B}) begin
            errors++; $display("FAIL rstmid_data got ai=%h bi=%h res=%h gi=%h want 0 0 0 100b", ai, bi, res_data, gi); end
        r0_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        seen = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_discard got %0d valid cycles want 0", seen); end
        issue_op(1'b0, 16'h0005, 16'h0007, ok);
        wait_result(LAT + 10, d, id, got);
        checks++; if (!ok || !got || {id, d} !== {1'b0, 16'h001B}) begin
            errors++; $display("FAIL rstmid_new_op got id %b data %h (seen %0d) want id 0 data 001b", id, d, got); end
    endtask

    // Sequence and report.
    initial begin
        test_reset();
        test_single_op();
        test_reduction();
        test_contention();
        test_backpressure();
        test_cfg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
